pll_clken_gen: RTL
==================

// Module: pll_clken_gen
// PURPOSE
//  Multi-channel fractional clock-enable generator; runs on one PLL output clock.
//  Replaces extra PLL output clocks with single-cycle enables, so all core logic
//  stays in one clock domain.
//  Qualifies enables on PLL lock plus a hold-off, and allows run-time ratio changes.
//  Changes take effect at a channel's next enable pulse, so no enable is glitched.
// PARAMETERS
//  NUM_CH     4       number of enable channels (1..16)
//  ACC_W      16      phase-accumulator width; ratio = inc / 2^ACC_W
//  LOCK_WAIT  1024    refclk cycles of stable lock required before enables run (>=1)
//  DEF_INC    0       increment loaded into every channel at reset
// PORTS
//  refclk      in   1                   PLL output clock, sole clock
//  rst         in   1                   async active-high reset
//  pll_locked  in   1                   PLL lock, asynchronous to refclk
//  cfg_valid   in   1                   increment write request
//  cfg_ready   out  1                   write accepted when cfg_valid & cfg_ready
//  cfg_ch      in   $clog2(NUM_CH)      target channel (max(1,...))
//  cfg_inc     in   ACC_W+1             new increment; values >2^ACC_W clamp to 2^ACC_W
//  phase_sync  in   1                   pulse: zero all accumulators together
//  ce          out  NUM_CH              per-channel one-cycle enable
//  ready       out  1                   high in RUN state
// BEHAVIOUR
//  Reset values: ce=0, ready=0, cfg_ready=1.
//   Internal reset values: acc=0, inc=DEF_INC, pending=0, state=WAIT_LOCK.
//  Lock input: pll_locked passes through a 2-FF synchroniser; lk is the synchronised value.
//  FSM:
//   WAIT_LOCK -> HOLDOFF when lk=1; the counter loads 0.
//   HOLDOFF counts while lk=1. It goes to RUN on the cycle the count reaches LOCK_WAIT-1.
//    If lk=0 it returns to WAIT_LOCK.
//   RUN -> WAIT_LOCK when lk=0. ce is forced 0 from that cycle, and all acc clear to 0.
//  Outside RUN: ce=0 and acc held at 0. Config writes load the active inc directly.
//  Accumulator, per channel in RUN:
//   sum = acc + inc, computed (ACC_W+1) bits wide.
//   acc <= sum[ACC_W-1:0] and ce <= sum[ACC_W], so ce is registered: 1 cycle after the carry.
//   inc=0 gives no pulses. inc=2^ACC_W gives ce every cycle.
//   Pulse count over 2^ACC_W cycles is exactly inc.
//  First ce after entering RUN or after phase_sync:
//   fires ceil(2^ACC_W/inc) cycles later, plus the 1 register cycle.
//  phase_sync in RUN: all acc <= 0 that cycle and no carry is taken. Ignored outside RUN.
//  Config handshake:
//   cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
//   In RUN, an accepted write stores the value in shadow[cfg_ch] and sets pending.
//   Shadow moves to inc on the cycle that channel carries; pending clears the same cycle.
//   That carry still uses the old inc.
//   If the active inc=0, the shadow applies on the next cycle (no deadlock).
//  Simultaneous events:
//   lk drop beats phase_sync, and both beat a carry.
//   A write to a channel whose pending clears that same cycle is refused (ready was 0).
//   A write accepted during a lk drop goes to the inc register, since state is not RUN.
//  rst mid-operation: everything returns to reset values asynchronously, including inc=DEF_INC.
// STRUCTURE
//  Package pll_clken_pkg:
//   state enum {WAIT_LOCK,HOLDOFF,RUN};
//   function clamp_inc(ACC_W);
//   localparam CH_W = max(1,$clog2(NUM_CH)).
//  Sub-module clken_acc_ch: one channel. Holds acc, inc, shadow, pending, and ce.
//   Its inputs are run, sync, wr, and wr_inc.
//   Generated NUM_CH times. The top level holds the synchroniser, FSM, hold-off counter,
//   and cfg decode.
// TESTING (ACC_W=16, NUM_CH=4, LOCK_WAIT=8)
//  1 Lock bring-up: rst, then pll_locked=1.
//    -> ready rises exactly 2+8 cycles later. ce stays 0 throughout.
//  2 Ratios: inc 0x8000 / 0x5555 / 0x10000 / 0.
//    -> ce every 2nd cycle / exactly 21845 pulses per 65536 cycles / every cycle / never.
//  3 Glitch-free change: ch0 at 0x4000 (every 4 cycles), write 0x8000 mid-period.
//    -> cfg_ready=0 for ch0 until its next ce. The following period is 2 cycles.
//    -> ch1 writes are still accepted meanwhile.
//  4 phase_sync with ch0=0x4000 and ch1=0x2000 running:
//    -> ch0 ce 4+1 cycles later and ch1 8+1 later, with coincident ce every 8 cycles.
//  5 Lock loss: drop pll_locked in RUN.
//    -> ce=0 and ready=0 within 3 cycles. A relock glitch shorter than 8 cycles does not set ready.
//  6 Async reset mid-RUN with a pending write:
//    -> ce=0 immediately, and after release inc=DEF_INC with no pending write.

Source files
------------

// File: rtl/pll_clken_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clken_pkg
//  Description : Shared types and helpers for the fractional clock-enable
//                generator (FSM states, channel-select width, increment clamp).
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RUN       = 2'd2
    } state_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Saturates an increment at 2^acc_w (one enable every cycle); acc_w <= 32.
    function automatic logic [32:0] clamp_inc(input logic [32:0] inc, input int acc_w);
        logic [32:0] lim;
        lim = 33'd1 << acc_w;
        return (inc > lim) ? lim : inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clken_acc_ch.sv
`default_nettype none
// ============================================================================
//  Module      : clken_acc_ch
//  Description : One enable channel: phase accumulator, active and shadow
//                increment, pending flag and registered carry enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module clken_acc_ch #(
    parameter int              ACC_W   = 16,
    parameter logic [ACC_W:0]  DEF_INC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [ACC_W:0]   wr_inc,
    output logic             pending,
    output logic             ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   r_inc;
    logic [ACC_W:0]   r_shadow;
    logic             r_pending;
    logic             r_ce;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_apply;

    assign w_sum   = {1'b0, r_acc} + r_inc;
    assign w_carry = run && !sync && w_sum[ACC_W];
    // A zero increment never carries, so its shadow is taken straight away.
    assign w_apply = run && r_pending && (w_carry || (r_inc == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_inc     <= DEF_INC;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_ce      <= 1'b0;
        end else begin
            if (run && !sync) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end else begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end

            if (w_apply) begin
                r_inc     <= r_shadow;
                r_pending <= 1'b0;
            end else if (wr) begin
                if (run) begin
                    r_shadow  <= wr_inc;
                    r_pending <= 1'b1;
                end else begin
                    r_inc <= wr_inc;
                end
            end
        end
    end

    assign pending = r_pending;
    assign ce      = r_ce;

endmodule
`default_nettype wire

// File: rtl/pll_clken_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clken_gen
//  Description : Multi-channel fractional clock-enable generator running on a
//                single PLL clock, gated by synchronised lock plus hold-off.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_clken_gen
    import pll_clken_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          ACC_W     = 16,
    parameter int          LOCK_WAIT = 1024,
    parameter int unsigned DEF_INC   = 0
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          pll_locked,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
    input  logic [ACC_W:0]                cfg_inc,
    input  logic                          phase_sync,
    output logic [NUM_CH-1:0]             ce,
    output logic                          ready
);

    localparam int               c_CH_W     = ch_width(NUM_CH);
    localparam int               c_CNT_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((LOCK_WAIT >= 2) ? LOCK_WAIT - 2 : 0);
    localparam logic [ACC_W:0]   c_DEF_INC  = (ACC_W+1)'(clamp_inc(33'(DEF_INC), ACC_W));

    logic                 r_lk_meta;
    logic                 r_lk;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic                 w_run;
    logic                 w_sync;
    logic                 w_wr;
    logic [ACC_W:0]       w_inc_clamped;
    logic [NUM_CH-1:0]    w_pending;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk      <= r_lk_meta;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // RUN is entered on the edge where the hold-off count would reach LOCK_WAIT-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WAIT_LOCK: begin
                if (r_lk) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (LOCK_WAIT <= 1) ? RUN : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!r_lk) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            RUN: begin
                if (!r_lk) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    assign ready  = (r_state == RUN);
    assign w_run  = (r_state == RUN) && r_lk;
    assign w_sync = w_run && phase_sync;

    always_comb begin
        cfg_ready = 1'b1;
        if (32'(cfg_ch) < NUM_CH) begin
            cfg_ready = !w_pending[cfg_ch];
        end
    end

    assign w_wr          = cfg_valid && cfg_ready;
    assign w_inc_clamped = (ACC_W+1)'(clamp_inc(33'(cfg_inc), ACC_W));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr && (cfg_ch == c_CH_W'(g));

        clken_acc_ch #(
            .ACC_W   (ACC_W),
            .DEF_INC (c_DEF_INC)
        ) u_ch (
            .clk     (refclk),
            .rst     (rst),
            .run     (w_run),
            .sync    (w_sync),
            .wr      (w_sel),
            .wr_inc  (w_inc_clamped),
            .pending (w_pending[g]),
            .ce      (ce[g])
        );
    end

endmodule
`default_nettype wire
